// File: rtl/vote_tally.sv
// vote_tally: multi-candidate ballot counter.
//   One push-button level per candidate; a single rising edge while polls are
//   open counts one vote, then a lockout window blocks further votes.
//   Simultaneous presses and votes for a saturated candidate are refused.
// Ports:
//   clk            - system clock, rising edge
//   resetCounter_n - asynchronous active-low reset
//   clear          - synchronous clear of all tallies (priority over voting)
//   vote_en        - polls open
//   vote_in        - per-candidate button levels (synchronised, debounced)
//   count_out      - candidate i count at [i*CNT_W +: CNT_W]
//   total_out      - sum of all counts
//   leader_out     - lowest index holding the maximum count
//   tie            - two or more candidates hold the maximum
//   accept/reject  - one-cycle result pulses
//   busy           - lockout active

// Per-candidate saturating counter.
module vote_tally_lane #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_sat
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc && !o_sat)
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign o_cnt = r_cnt;
    assign o_sat = &r_cnt;
endmodule

module vote_tally #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 10,
    parameter int LOCK_CYC = 8,
    localparam int TOT_W   = CNT_W + $clog2(NUM_CAND),
    localparam int LEAD_W  = ($clog2(NUM_CAND) > 1) ? $clog2(NUM_CAND) : 1
) (
    input  logic                      clk,
    input  logic                      resetCounter_n,
    input  logic                      clear,
    input  logic                      vote_en,
    input  logic [NUM_CAND-1:0]       vote_in,
    output logic [NUM_CAND*CNT_W-1:0] count_out,
    output logic [TOT_W-1:0]          total_out,
    output logic [LEAD_W-1:0]         leader_out,
    output logic                      tie,
    output logic                      accept,
    output logic                      reject,
    output logic                      busy
);
    localparam int TMR_W = $clog2(LOCK_CYC + 1);
    localparam logic [NUM_CAND-1:0] LSB1 = {{(NUM_CAND-1){1'b0}}, 1'b1};

    typedef enum logic {S_IDLE, S_LOCK} state_t;

    state_t                         r_state, w_state_nxt;
    logic [TMR_W-1:0]               r_tmr, w_tmr_nxt;
    logic [NUM_CAND-1:0]            r_prev;
    logic [TOT_W-1:0]               r_total;
    logic                           r_accept, r_reject;
    logic                           w_acc_nxt, w_rej_nxt, w_take;
    logic [NUM_CAND-1:0]            w_rise, w_inc, w_sat;
    logic                           w_single, w_hit_sat;
    logic [NUM_CAND-1:0][CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0]               w_max;
    logic [LEAD_W-1:0]              w_lead;
    logic                           w_seen, w_tie;

    // Edge register runs unconditionally, so a button held through lockout
    // has already been absorbed into r_prev and cannot vote later.
    always_ff @(posedge clk or negedge resetCounter_n) begin
        if (!resetCounter_n) r_prev <= '0;
        else                 r_prev <= vote_in;
    end

    assign w_rise    = vote_in & ~r_prev;
    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign w_single  = (w_rise != '0) && ((w_rise & (w_rise - LSB1)) == '0);
    // Only meaningful when w_single; selects the saturation flag of that lane.
    assign w_hit_sat = |(w_rise & w_sat);
    assign w_inc     = w_take ? w_rise : '0;

    genvar g;
    generate
        for (g = 0; g < NUM_CAND; g++) begin : g_lane
            vote_tally_lane #(.CNT_W(CNT_W)) u_lane (
                .clk   (clk),
                .rst_n (resetCounter_n),
                .i_clr (clear),
                .i_inc (w_inc[g]),
                .o_cnt (w_cnt[g]),
                .o_sat (w_sat[g])
            );
            assign count_out[g*CNT_W +: CNT_W] = w_cnt[g];
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_acc_nxt   = 1'b0;
        w_rej_nxt   = 1'b0;
        w_take      = 1'b0;
        if (clear) begin
            w_state_nxt = S_IDLE;
            w_tmr_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (vote_en && (w_rise != '0)) begin
                        if (w_single && !w_hit_sat) begin
                            w_take      = 1'b1;
                            w_acc_nxt   = 1'b1;
                            w_state_nxt = S_LOCK;
                            w_tmr_nxt   = TMR_W'(LOCK_CYC);
                        end else begin
                            w_rej_nxt   = 1'b1;
                        end
                    end
                end
                S_LOCK: begin
                    // Leaving on timer==1 gives exactly LOCK_CYC busy cycles.
                    if (r_tmr == TMR_W'(1)) begin
                        w_state_nxt = S_IDLE;
                        w_tmr_nxt   = '0;
                    end else begin
                        w_tmr_nxt   = r_tmr - TMR_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_tmr_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetCounter_n) begin
        if (!resetCounter_n) begin
            r_state  <= S_IDLE;
            r_tmr    <= '0;
            r_accept <= 1'b0;
            r_reject <= 1'b0;
            r_total  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_tmr    <= w_tmr_nxt;
            r_accept <= w_acc_nxt;
            r_reject <= w_rej_nxt;
            if (clear)       r_total <= '0;
            else if (w_take) r_total <= r_total + TOT_W'(1);
        end
    end

    // Strict '>' keeps the lowest index on equal counts.
    always_comb begin
        w_max  = '0;
        w_lead = '0;
        w_seen = 1'b0;
        w_tie  = 1'b0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (w_cnt[i] > w_max) begin
                w_max  = w_cnt[i];
                w_lead = LEAD_W'(i);
            end
        end
        for (int i = 0; i < NUM_CAND; i++) begin
            if (w_cnt[i] == w_max) begin
                if (w_seen) w_tie = 1'b1;
                w_seen = 1'b1;
            end
        end
    end

    assign total_out  = r_total;
    assign leader_out = w_lead;
    assign tie        = w_tie;
    assign accept     = r_accept;
    assign reject     = r_reject;
    assign busy       = (r_state == S_LOCK);
endmodule

// File: tb/tb_vote_tally.sv
// Bench for vote_tally: NUM_CAND=4, CNT_W=3 (saturates at 7), LOCK_CYC=8.
// A vote-level model runs alongside and is compared every falling edge;
// directed steps add literal expectations.
module tb_vote_tally;
    localparam int NC = 4;
    localparam int CW = 3;
    localparam int LC = 8;
    localparam int MAXC = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          en = 1'b0;
    logic [NC-1:0] vin = '0;
    logic [NC*CW-1:0] count_out;
    logic [4:0]    total_out;
    logic [1:0]    leader_out;
    logic          tie, accept, reject, busy;

    int checks = 0;
    int failures = 0;

    vote_tally #(.NUM_CAND(NC), .CNT_W(CW), .LOCK_CYC(LC)) dut (
        .clk            (clk),
        .resetCounter_n (rst_n),
        .clear          (clr),
        .vote_en        (en),
        .vote_in        (vin),
        .count_out      (count_out),
        .total_out      (total_out),
        .leader_out     (leader_out),
        .tie            (tie),
        .accept         (accept),
        .reject         (reject),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int cnt_of(input int i);
        logic [NC*CW-1:0] v;
        v = count_out;
        return int'(v[i*CW +: CW]);
    endfunction

    // ---------------- vote-level model ----------------
    int       m_cnt [NC] = '{default: 0};
    int       m_tot  = 0;
    int       m_lock = 0;     // lockout cycles remaining
    logic [NC-1:0] m_prev = '0;
    bit       m_acc = 0, m_rej = 0;

    always @(posedge clk or negedge rst_n) begin
        logic [NC-1:0] r;
        int c;
        if (!rst_n) begin
            for (int i = 0; i < NC; i++) m_cnt[i] = 0;
            m_tot = 0; m_lock = 0; m_prev = '0; m_acc = 0; m_rej = 0;
        end else begin
            r = vin & ~m_prev;
            m_prev = vin;
            m_acc = 0; m_rej = 0;
            if (clr) begin
                for (int i = 0; i < NC; i++) m_cnt[i] = 0;
                m_tot = 0; m_lock = 0;
            end else if (m_lock > 0) begin
                m_lock--;
            end else if (en && r != '0) begin
                if ($countones(r) == 1) begin
                    c = 0;
                    for (int i = 0; i < NC; i++) if (r[i]) c = i;
                    if (m_cnt[c] < MAXC) begin
                        m_cnt[c]++; m_tot++; m_acc = 1; m_lock = LC;
                    end else m_rej = 1;
                end else m_rej = 1;
            end
        end
    end

    function automatic int m_leader();
        int best = 0;
        for (int i = 1; i < NC; i++) if (m_cnt[i] > m_cnt[best]) best = i;
        return best;
    endfunction

    function automatic int m_tie();
        int n = 0;
        for (int i = 0; i < NC; i++) if (m_cnt[i] == m_cnt[m_leader()]) n++;
        return (n >= 2) ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < NC; i++) chk($sformatf("model count%0d", i), cnt_of(i), m_cnt[i]);
        chk("model total",  int'(total_out), m_tot);
        chk("model leader", int'(leader_out), m_leader());
        chk("model tie",    int'(tie), m_tie());
        chk("model accept", int'(accept), int'(m_acc));
        chk("model reject", int'(reject), int'(m_rej));
        chk("model busy",   int'(busy), (m_lock > 0) ? 1 : 0);
    end

    // Drive a one-cycle level: sampled at the next rising edge, returns 2ns after it.
    task automatic press(input logic [NC-1:0] v);
        vin = v;
        @(posedge clk); #2;
        vin = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int bc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset count_out", int'(count_out), 0);
        chk("reset total",     int'(total_out), 0);
        chk("reset busy",      int'(busy), 0);
        chk("reset leader",    int'(leader_out), 0);
        chk("reset tie",       int'(tie), 1);
        @(posedge clk); #2;
        rst_n = 1'b1; en = 1'b1;
        idle(2);

        // single vote, accept pulse, busy exactly LOCK_CYC cycles
        press(4'b0001);
        @(negedge clk);
        chk("vote1 count0", cnt_of(0), 1);
        chk("vote1 total",  int'(total_out), 1);
        chk("vote1 accept", int'(accept), 1);
        chk("vote1 leader", int'(leader_out), 0);
        chk("vote1 tie",    int'(tie), 0);
        bc = busy ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) bc++;
        end
        chk("vote1 busy cycles", bc, LC);
        idle(1);

        // held button: one vote only
        vin = 4'b0100;
        idle(20);
        vin = '0;
        idle(12);
        @(negedge clk);
        chk("held count2", cnt_of(2), 1);
        chk("held total",  int'(total_out), 2);
        idle(1);

        // simultaneous presses are refused
        press(4'b0110);
        @(negedge clk);
        chk("multi reject", int'(reject), 1);
        chk("multi busy",   int'(busy), 0);
        chk("multi count1", cnt_of(1), 0);
        idle(2);

        // vote at k, ignored press at k+3, accepted press at k+9
        press(4'b0001);
        idle(2);
        press(4'b1000);
        @(negedge clk);
        chk("lock ignore accept", int'(accept), 0);
        chk("lock ignore reject", int'(reject), 0);
        chk("lock ignore count3", cnt_of(3), 0);
        idle(5);
        press(4'b1000);
        @(negedge clk);
        chk("k+9 accept", int'(accept), 1);
        chk("k+9 count3", cnt_of(3), 1);
        idle(10);

        // two votes for candidate 1 -> counts 2,2,1,1
        press(4'b0010); idle(10);
        press(4'b0010); idle(10);
        @(negedge clk);
        chk("pre-clear count1", cnt_of(1), 2);
        chk("pre-clear tie",    int'(tie), 1);
        #1;
        // clear together with a fresh rise: rise dropped
        clr = 1'b1; vin = 4'b0001;
        @(posedge clk); #2;
        clr = 1'b0; vin = '0;
        @(negedge clk);
        chk("clear count_out", int'(count_out), 0);
        chk("clear total",     int'(total_out), 0);
        chk("clear accept",    int'(accept), 0);
        chk("clear busy",      int'(busy), 0);
        idle(2);

        // saturation at 7, eighth press rejected
        for (int n = 0; n < 8; n++) begin
            press(4'b0010);
            @(negedge clk);
            if (n < 7) chk("sat accept", int'(accept), 1);
            else       chk("sat reject", int'(reject), 1);
            idle(9);
        end
        @(negedge clk);
        chk("sat count1", cnt_of(1), 7);
        chk("sat total",  int'(total_out), 7);
        chk("sat leader", int'(leader_out), 1);
        chk("sat tie",    int'(tie), 0);
        idle(1);

        // async reset mid-lockout
        press(4'b0001);
        @(negedge clk);
        chk("pre-reset busy", int'(busy), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset busy",  int'(busy), 0);
        chk("async reset count", int'(count_out), 0);
        chk("async reset total", int'(total_out), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
